// File: rtl/dns_query_parse.sv
// DNS query parser: validates the 12-byte header of a captured payload, then walks the
// first question's QNAME one byte per cycle and presents ID/flags/QNAME/QTYPE/QCLASS or an error.
module dns_query_parse #(
    parameter int PKT_BYTES    = 512,
    parameter int MAX_NAME_LEN = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_dns_valid,
    output logic                      s_dns_ready,
    input  logic [31:0]               s_udp_src_ip,
    input  logic [31:0]               s_udp_dst_ip,
    input  logic [15:0]               s_udp_length,
    input  logic [8*PKT_BYTES-1:0]    s_dns_pkt,
    output logic                      m_query_valid,
    input  logic                      m_query_ready,
    output logic [31:0]               m_src_ip,
    output logic [31:0]               m_dst_ip,
    output logic [15:0]               m_dns_id,
    output logic [15:0]               m_dns_flags,
    output logic [8*MAX_NAME_LEN-1:0] m_qname,
    output logic [7:0]                m_qname_len,
    output logic [15:0]               m_qtype,
    output logic [15:0]               m_qclass,
    output logic [2:0]                m_error
);

    localparam int IW = $clog2(PKT_BYTES);
    localparam int QW = (MAX_NAME_LEN > 1) ? $clog2(MAX_NAME_LEN) : 1;

    localparam logic [2:0] E_OK          = 3'd0;
    localparam logic [2:0] E_LEN_SHORT   = 3'd1;
    localparam logic [2:0] E_NOT_QUERY   = 3'd2;
    localparam logic [2:0] E_NO_QUESTION = 3'd3;
    localparam logic [2:0] E_COMPRESS    = 3'd4;
    localparam logic [2:0] E_TRUNC       = 3'd5;
    localparam logic [2:0] E_NAME_LONG   = 3'd6;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_NAME, S_TAIL, S_OUT} state_t;

    state_t      r_state;
    logic        r_ready;
    logic        r_valid;
    logic [7:0]  r_pkt [PKT_BYTES];
    logic [15:0] r_len;
    logic [9:0]  r_idx;
    logic [7:0]  r_label_rem;
    logic [1:0]  r_tail_cnt;
    logic [31:0] r_src_ip;
    logic [31:0] r_dst_ip;
    logic [15:0] r_id;
    logic [15:0] r_flags;
    logic [7:0]  r_qname_b [MAX_NAME_LEN];
    logic [7:0]  r_qname_len;
    logic [15:0] r_qtype;
    logic [15:0] r_qclass;
    logic [2:0]  r_error;

    logic [7:0]  w_pkt_in [PKT_BYTES];
    logic [7:0]  w_byte;
    logic [15:0] w_flags;
    logic [15:0] w_qdcount;
    logic [15:0] w_len_clamp;
    logic [9:0]  w_idx_inc;
    logic        w_accept;
    logic        w_past_end;
    logic        w_len_byte;
    logic        w_terminator;
    logic        w_name_full;
    logic [2:0]  w_err;

    for (genvar g = 0; g < PKT_BYTES; g++) begin : g_unpack
        assign w_pkt_in[g] = s_dns_pkt[8*(PKT_BYTES-1-g) +: 8];
    end

    for (genvar g = 0; g < MAX_NAME_LEN; g++) begin : g_pack
        assign m_qname[8*(MAX_NAME_LEN-1-g) +: 8] = r_qname_b[g];
    end

    assign w_byte       = r_pkt[r_idx[IW-1:0]];
    assign w_flags      = {r_pkt[2], r_pkt[3]};
    assign w_qdcount    = {r_pkt[4], r_pkt[5]};
    assign w_len_clamp  = (s_udp_length > 16'(PKT_BYTES)) ? 16'(PKT_BYTES) : s_udp_length;
    assign w_idx_inc    = (r_idx == 10'h3FF) ? r_idx : r_idx + 10'd1;
    assign w_accept     = (r_state == S_IDLE) && s_dns_valid && r_ready;
    assign w_past_end   = {6'd0, r_idx} >= r_len;
    assign w_len_byte   = (r_label_rem == 8'd0);
    assign w_terminator = w_len_byte && (w_byte == 8'd0);
    assign w_name_full  = (r_qname_len == 8'(MAX_NAME_LEN));

    // Error detected in the current cycle; a non-OK value ends the parse next cycle.
    always_comb begin
        w_err = E_OK;
        case (r_state)
            S_HDR: begin
                if (r_len < 16'd12)                               w_err = E_LEN_SHORT;
                else if (w_flags[15] || (w_flags[14:11] != 4'd0)) w_err = E_NOT_QUERY;
                else if (w_qdcount == 16'd0)                      w_err = E_NO_QUESTION;
            end
            S_NAME: begin
                if (w_past_end)                                   w_err = E_TRUNC;
                else if (w_len_byte && (w_byte[7:6] != 2'b00))    w_err = E_COMPRESS;
                else if (!w_terminator && w_name_full)            w_err = E_NAME_LONG;
            end
            S_TAIL: begin
                if (w_past_end)                                   w_err = E_TRUNC;
            end
            default: ;
        endcase
    end

    // NOTE: the packet buffer carries no reset; it is fully overwritten on every accept
    // and never read before that, so resetting it would only add fan-out.
    always_ff @(posedge clk) begin
        if (w_accept) r_pkt <= w_pkt_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_valid     <= 1'b0;
            r_len       <= 16'd0;
            r_idx       <= 10'd0;
            r_label_rem <= 8'd0;
            r_tail_cnt  <= 2'd0;
            r_src_ip    <= 32'd0;
            r_dst_ip    <= 32'd0;
            r_id        <= 16'd0;
            r_flags     <= 16'd0;
            r_qname_b   <= '{default: 8'h00};
            r_qname_len <= 8'd0;
            r_qtype     <= 16'd0;
            r_qclass    <= 16'd0;
            r_error     <= E_OK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ready     <= 1'b0;
                        r_src_ip    <= s_udp_src_ip;
                        r_dst_ip    <= s_udp_dst_ip;
                        r_len       <= w_len_clamp;
                        r_id        <= 16'd0;
                        r_flags     <= 16'd0;
                        r_qname_b   <= '{default: 8'h00};
                        r_qname_len <= 8'd0;
                        r_qtype     <= 16'd0;
                        r_qclass    <= 16'd0;
                        r_error     <= E_OK;
                        r_state     <= S_HDR;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_HDR: begin
                    r_id    <= {r_pkt[0], r_pkt[1]};
                    r_flags <= w_flags;
                    if (w_err != E_OK) begin
                        r_error <= w_err;
                        r_valid <= 1'b1;
                        r_state <= S_OUT;
                    end else begin
                        r_idx       <= 10'd12;
                        r_label_rem <= 8'd0;
                        r_state     <= S_NAME;
                    end
                end
                S_NAME: begin
                    r_idx <= w_idx_inc;
                    if (w_err != E_OK) begin
                        r_error <= w_err;
                        r_valid <= 1'b1;
                        r_state <= S_OUT;
                    end else if (w_terminator) begin
                        r_tail_cnt <= 2'd0;
                        r_state    <= S_TAIL;
                    end else begin
                        r_label_rem                      <= w_len_byte ? w_byte : r_label_rem - 8'd1;
                        r_qname_b[r_qname_len[QW-1:0]]   <= w_byte;
                        r_qname_len                      <= r_qname_len + 8'd1;
                    end
                end
                S_TAIL: begin
                    r_idx      <= w_idx_inc;
                    r_tail_cnt <= r_tail_cnt + 2'd1;
                    if (w_err != E_OK) begin
                        r_error <= w_err;
                        r_valid <= 1'b1;
                        r_state <= S_OUT;
                    end else begin
                        case (r_tail_cnt)
                            2'd0: r_qtype[15:8]  <= w_byte;
                            2'd1: r_qtype[7:0]   <= w_byte;
                            2'd2: r_qclass[15:8] <= w_byte;
                            default: begin
                                r_qclass[7:0] <= w_byte;
                                r_valid       <= 1'b1;
                                r_state       <= S_OUT;
                            end
                        endcase
                    end
                end
                S_OUT: begin
                    if (m_query_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_dns_ready   = r_ready;
    assign m_query_valid = r_valid;
    assign m_src_ip      = r_src_ip;
    assign m_dst_ip      = r_dst_ip;
    assign m_dns_id      = r_id;
    assign m_dns_flags   = r_flags;
    assign m_qname_len   = r_qname_len;
    assign m_qtype       = r_qtype;
    assign m_qclass      = r_qclass;
    assign m_error       = r_error;

endmodule
